// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit processor boot/run sequencer:
// opcodes, program-memory geometry and the sequencer state encoding.
package proc_pkg;

    localparam int PM_DEPTH = 16;
    localparam int WORD_W   = 8;
    localparam int PTR_W    = 4;
    localparam int LEN_W    = 5;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_LDI = 4'b0110;
    localparam logic [3:0] OP_OUT = 4'b0111;
    localparam logic [3:0] OP_IN  = 4'b1000;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_JZ  = 4'b1010;
    localparam logic [3:0] OP_JNC = 4'b1011;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RST1  = 3'd2,
        BURST = 3'd3,
        RST2  = 3'd4,
        RUN   = 3'd5,
        DONE  = 3'd6
    } seq_state_e;

    // Slots beyond the loaded program get this word instead of buffer contents.
    function automatic logic [WORD_W-1:0] burst_word(
        input logic [PTR_W-1:0]  ptr,
        input logic [LEN_W-1:0]  len,
        input logic [WORD_W-1:0] buf_word,
        input logic [WORD_W-1:0] fill_word
    );
        if ({1'b0, ptr} < len) begin
            return buf_word;
        end else begin
            return fill_word;
        end
    endfunction

endpackage

// File: rtl/prog_buffer.sv
// 16x8 program staging buffer: one synchronous write port, one
// asynchronous read port, no reset on the storage array.
module prog_buffer
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [PM_DEPTH];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader_seq.sv
// Boot/run sequencer: buffers a host program, replays it into the core's
// program memory as one gap-free 16-cycle burst, then runs the core.
module prog_loader_seq
    import proc_pkg::*;
#(
    parameter logic [7:0] FILL_WORD  = 8'h90,
    parameter int         RUN_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic [7:0] host_data,
    input  logic       host_last,
    input  logic       abort,
    input  logic       restart,
    output logic       cpu_pc_reset,
    output logic       cpu_mem_write,
    output logic [3:0] cpu_instr,
    output logic [3:0] cpu_portin,
    output logic       busy,
    output logic       done,
    output logic [4:0] prog_len
);

    localparam int CNT_W = (RUN_CYCLES > 0) ? $clog2(RUN_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic             BOUNDED  = (RUN_CYCLES != 0);

    seq_state_e        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic [LEN_W-1:0]  prog_len_q, prog_len_d;
    logic              pc_reset_q, pc_reset_d;
    logic              mem_write_q, mem_write_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              done_q, done_d;

    logic              beat_s;
    logic              buf_we_s;
    logic [PTR_W-1:0]  buf_waddr_s;
    logic [WORD_W-1:0] buf_rdata_s;

    assign host_ready = (state_q == IDLE) || (state_q == FILL);
    assign beat_s     = host_valid & host_ready;

    prog_buffer u_buf (
        .clk   (clk),
        .we    (buf_we_s),
        .waddr (buf_waddr_s),
        .wdata (host_data),
        .raddr (rd_ptr_d),
        .rdata (buf_rdata_s)
    );

    // Next-state, pointer and counter logic; abort outranks restart.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        run_cnt_d   = run_cnt_q;
        prog_len_d  = prog_len_q;
        buf_we_s    = 1'b0;
        buf_waddr_s = wr_ptr_q;
        if (abort) begin
            state_d  = IDLE;
            wr_ptr_d = 4'd0;
            rd_ptr_d = 4'd0;
        end else if (restart && (state_q == DONE)) begin
            state_d  = IDLE;
            wr_ptr_d = 4'd0;
            rd_ptr_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat_s) begin
                        buf_we_s    = 1'b1;
                        buf_waddr_s = 4'd0;
                        if (host_last) begin
                            prog_len_d = 5'd1;
                            state_d    = RST1;
                        end else begin
                            wr_ptr_d = 4'd1;
                            state_d  = FILL;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                FILL: begin
                    if (beat_s) begin
                        buf_we_s = 1'b1;
                        wr_ptr_d = wr_ptr_q + 4'd1;
                        if (host_last || (wr_ptr_q == 4'd15)) begin
                            prog_len_d = {1'b0, wr_ptr_q} + 5'd1;
                            state_d    = RST1;
                        end else begin
                            state_d = FILL;
                        end
                    end else begin
                        state_d = FILL;
                    end
                end
                RST1: begin
                    rd_ptr_d = 4'd0;
                    state_d  = BURST;
                end
                BURST: begin
                    rd_ptr_d = rd_ptr_q + 4'd1;
                    if (rd_ptr_q == 4'd15) begin
                        state_d = RST2;
                    end else begin
                        state_d = BURST;
                    end
                end
                RST2: begin
                    run_cnt_d = {CNT_W{1'b0}};
                    state_d   = RUN;
                end
                RUN: begin
                    if (run_cnt_q != CNT_MAX) begin
                        run_cnt_d = run_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        run_cnt_d = run_cnt_q;
                    end
                    if (BOUNDED && (run_cnt_q == CNT_LAST)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Moore outputs are decoded from the state being entered so they flop with it.
    always_comb begin
        pc_reset_d  = 1'b1;
        mem_write_d = 1'b0;
        word_d      = 8'h00;
        done_d      = 1'b0;
        case (state_d)
            BURST: begin
                pc_reset_d  = 1'b0;
                mem_write_d = 1'b1;
                word_d      = burst_word(rd_ptr_d, prog_len_d, buf_rdata_s, FILL_WORD);
            end
            RUN: begin
                pc_reset_d = 1'b0;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                pc_reset_d = 1'b1;
            end
        endcase
    end

    // State, pointers, counter and registered core-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= 4'd0;
            rd_ptr_q    <= 4'd0;
            run_cnt_q   <= {CNT_W{1'b0}};
            prog_len_q  <= 5'd0;
            pc_reset_q  <= 1'b1;
            mem_write_q <= 1'b0;
            word_q      <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            run_cnt_q   <= run_cnt_d;
            prog_len_q  <= prog_len_d;
            pc_reset_q  <= pc_reset_d;
            mem_write_q <= mem_write_d;
            word_q      <= word_d;
            done_q      <= done_d;
        end
    end

    assign cpu_pc_reset  = pc_reset_q;
    assign cpu_mem_write = mem_write_q;
    assign cpu_instr     = word_q[7:4];
    assign cpu_portin    = word_q[3:0];
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = done_q;
    assign prog_len      = prog_len_q;

endmodule

// File: tb/tb_prog_loader_seq.sv
// Directed, table-driven bench for prog_loader_seq; a second instance with
// RUN_CYCLES=0 shares all inputs to cover the unbounded-run case.
module tb_prog_loader_seq;

    logic       clk;
    logic       rst_n;
    logic       host_valid;
    logic [7:0] host_data;
    logic       host_last;
    logic       abort;
    logic       restart;

    logic       host_ready,  cpu_pc_reset,  cpu_mem_write,  busy,  done;
    logic [3:0] cpu_instr,   cpu_portin;
    logic [4:0] prog_len;
    logic       host_ready0, cpu_pc_reset0, cpu_mem_write0, busy0, done0;
    logic [3:0] cpu_instr0,  cpu_portin0;
    logic [4:0] prog_len0;

    prog_loader_seq #(.FILL_WORD(8'h90), .RUN_CYCLES(20)) dut (
        .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(host_ready),
        .host_data(host_data), .host_last(host_last), .abort(abort), .restart(restart),
        .cpu_pc_reset(cpu_pc_reset), .cpu_mem_write(cpu_mem_write), .cpu_instr(cpu_instr),
        .cpu_portin(cpu_portin), .busy(busy), .done(done), .prog_len(prog_len)
    );

    prog_loader_seq #(.FILL_WORD(8'h90), .RUN_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(host_ready0),
        .host_data(host_data), .host_last(host_last), .abort(abort), .restart(restart),
        .cpu_pc_reset(cpu_pc_reset0), .cpu_mem_write(cpu_mem_write0), .cpu_instr(cpu_instr0),
        .cpu_portin(cpu_portin0), .busy(busy0), .done(done0), .prog_len(prog_len0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hv;
        logic [7:0]  hd;
        logic        hl;
        logic        ab;
        logic        rs;
        logic [12:0] exp;
        logic        chk_len;
        logic [4:0]  len;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] prog[16];
    int         n_cmp = 0;
    int         n_bad = 0;
    string      tag;

    // {pc_reset, mem_write, instr, portin, busy, done, host_ready}
    function automatic logic [12:0] e(input logic pcr, input logic mw, input logic [7:0] w,
                                      input logic bsy, input logic dn, input logic rdy);
        return {pcr, mw, w, bsy, dn, rdy};
    endfunction

    function automatic logic [12:0] obs_main();
        return {cpu_pc_reset, cpu_mem_write, cpu_instr, cpu_portin, busy, done, host_ready};
    endfunction

    function automatic logic [12:0] obs_zero();
        return {cpu_pc_reset0, cpu_mem_write0, cpu_instr0, cpu_portin0, busy0, done0, host_ready0};
    endfunction

    task automatic add(input logic hv, input logic [7:0] hd, input logic hl, input logic ab,
                       input logic rs, input logic [12:0] ex, input logic cl, input logic [4:0] ln);
        vec_t v;
        v.hv = hv; v.hd = hd; v.hl = hl; v.ab = ab; v.rs = rs;
        v.exp = ex; v.chk_len = cl; v.len = ln;
        vq.push_back(v);
    endtask

    task automatic cmp(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h ({pcr,mw,instr,portin,busy,done,ready})", nm, act, exp);
        end
    endtask

    task automatic cmp_len(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: prog_len got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Load n words of prog[] with optional host_last on the final word; ends in RST1.
    task automatic push_load(input int n, input logic use_last, input logic [4:0] exp_len);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1)
                add(1'b1, prog[i], use_last, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0), 1'b1, exp_len);
            else
                add(1'b1, prog[i], 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1), 1'b0, 5'd0);
        end
    endtask

    // 16 contiguous write cycles (prog words then JMP 0 fill), then RST2.
    task automatic push_burst(input int n);
        for (int i = 0; i < 16; i++)
            add(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0,
                e(1'b0, 1'b1, (i < n) ? prog[i] : 8'h90, 1'b1, 1'b0, 1'b0), 1'b0, 5'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0), 1'b0, 5'd0);
    endtask

    task automatic push_run(input int cycles, input logic reach_done);
        for (int i = 0; i < cycles; i++)
            add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0), 1'b0, 5'd0);
        if (reach_done)
            add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0), 1'b0, 5'd0);
    endtask

    task automatic apply();
        for (int i = 0; i < vq.size(); i++) begin
            host_valid = vq[i].hv;
            host_data  = vq[i].hd;
            host_last  = vq[i].hl;
            abort      = vq[i].ab;
            restart    = vq[i].rs;
            @(posedge clk);
            #1;
            cmp($sformatf("%s[%0d]", tag, i), obs_main(), vq[i].exp);
            if (vq[i].chk_len)
                cmp_len($sformatf("%s_len[%0d]", tag, i), prog_len, vq[i].len);
        end
        host_valid = 1'b0; host_data = 8'h00; host_last = 1'b0; abort = 1'b0; restart = 1'b0;
        vq.delete();
    endtask

    initial begin
        rst_n = 1'b0; host_valid = 1'b0; host_data = 8'h00; host_last = 1'b0;
        abort = 1'b0; restart = 1'b0;
        #12;
        tag = "reset";
        cmp("reset_out", obs_main(), e(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        cmp_len("reset_len", prog_len, 5'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: three-word program, 20-cycle run, DONE holds, restart returns to IDLE
        tag = "t1";
        prog[0] = 8'h61; prog[1] = 8'h70; prog[2] = 8'h90;
        push_load(3, 1'b1, 5'd3);
        push_burst(3);
        push_run(20, 1'b1);
        add(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0), 1'b0, 5'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, e(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1), 1'b0, 5'd0);
        apply();

        // T2: 16 words without host_last; ready drops after the 16th beat
        tag = "t2";
        for (int i = 0; i < 16; i++) prog[i] = {4'(i), 4'(15 - i)};
        push_load(16, 1'b0, 5'd16);
        push_burst(16);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1), 1'b0, 5'd0);
        apply();

        // T3: host stalls 1-0-0-1-0-1 during FILL, no early memory writes
        tag = "t3";
        prog[0] = 8'hA3; prog[1] = 8'h5C; prog[2] = 8'h31; prog[3] = 8'h82;
        add(1'b1, prog[0], 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1), 1'b0, 5'd0);
        add(1'b1, prog[1], 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1), 1'b0, 5'd0);
        add(1'b0, 8'hEE,   1'b1, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1), 1'b0, 5'd0);
        add(1'b0, 8'hEE,   1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1), 1'b0, 5'd0);
        add(1'b1, prog[2], 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1), 1'b0, 5'd0);
        add(1'b0, 8'hEE,   1'b1, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1), 1'b0, 5'd0);
        add(1'b1, prog[3], 1'b1, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0), 1'b1, 5'd4);
        push_burst(4);
        push_run(1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1), 1'b0, 5'd0);
        apply();

        // T4: abort discards a simultaneous beat, then aborts in the 5th BURST cycle
        tag = "t4";
        add(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1), 1'b0, 5'd0);
        prog[0] = 8'h11; prog[1] = 8'h22;
        push_load(2, 1'b1, 5'd2);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0), 1'b0, 5'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0), 1'b0, 5'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b1, 8'h90, 1'b1, 1'b0, 1'b0), 1'b0, 5'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b1, 8'h90, 1'b1, 1'b0, 1'b0), 1'b0, 5'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b1, 8'h90, 1'b1, 1'b0, 1'b0), 1'b0, 5'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1), 1'b0, 5'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1), 1'b0, 5'd0);
        apply();

        // T5: asynchronous reset mid-RUN, between clock edges
        tag = "t5";
        prog[0] = 8'hC3;
        push_load(1, 1'b1, 5'd1);
        push_burst(1);
        push_run(3, 1'b0);
        apply();
        rst_n = 1'b0;
        #2;
        cmp("t5_async_rst", obs_main(), e(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        cmp_len("t5_async_len", prog_len, 5'd0);
        cmp("t5_async_rst0", obs_zero(), e(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tag = "t5_reload";
        prog[0] = 8'h61; prog[1] = 8'h70; prog[2] = 8'h90;
        push_load(3, 1'b1, 5'd3);
        push_burst(3);
        push_run(20, 1'b1);
        apply();

        // T6: unbounded instance keeps running, bounded one stays in DONE
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
        end
        cmp("t6_unbounded_run", obs_zero(), e(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        cmp("t6_bounded_done", obs_main(), e(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        cmp("t6_abort_unbounded", obs_zero(), e(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        cmp("t6_abort_bounded", obs_main(), e(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
